// File: rtl/fetch_pc_if.sv
// Fetch-side bus of fetch_pc: control inputs from the pipeline and the
// address/status outputs toward instruction memory and decode.
interface fetch_pc_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] Dir;
  logic [31:0] pc_plus4;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        addr_err;
  logic [15:0] fetch_count;
  // FSM state for observation: 0 = FILL, 1 = RUN, 2 = REDIRECT
  logic [1:0]  fsm_state;

  modport master (
    output stall, br_taken, br_target,
    input  Dir, pc_plus4, inst_pc, inst_valid, addr_err, fetch_count, fsm_state
  );

  modport slave (
    input  stall, br_taken, br_target,
    output Dir, pc_plus4, inst_pc, inst_valid, addr_err, fetch_count, fsm_state
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter for a memory with a one-cycle registered read. Tracks which
// address the word on Inst belongs to and whether it is on the correct path.
module fetch_pc #(
  parameter int unsigned MEM_BYTES = 80,
  parameter int unsigned RESET_PC  = 0
) (
  input logic        clk,
  input logic        rst,
  fetch_pc_if.slave  bus
);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [31:0] LAST_WORD  = 32'(MEM_BYTES) - 32'd4;
  localparam logic [31:0] RESET_ADDR = 32'(RESET_PC);

  state_t      state, state_nxt;
  logic [31:0] dir_q;
  logic [31:0] inst_pc_q;
  logic        valid_q;
  logic        err_q;
  logic [15:0] count_q;

  logic [31:0] seq_sum;
  logic [31:0] seq_pc;
  logic [31:0] tgt_aligned;
  logic        tgt_bad;
  logic        count_inc;

  always_comb begin
    seq_sum     = dir_q + 32'd4;
    seq_pc      = (seq_sum > LAST_WORD) ? 32'd0 : seq_sum;
    tgt_aligned = bus.br_target & ~32'd3;
    tgt_bad     = (tgt_aligned > LAST_WORD);
    // A delivered word is counted even if the same edge redirects.
    count_inc   = !bus.stall && valid_q && (count_q != 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.br_taken)    state_nxt = REDIRECT;
    else if (!bus.stall) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= RESET_ADDR;
      inst_pc_q <= RESET_ADDR;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      if (count_inc) count_q <= count_q + 16'd1;
      if (bus.br_taken) begin
        dir_q     <= tgt_bad ? 32'd0 : tgt_aligned;
        err_q     <= err_q | tgt_bad;
        inst_pc_q <= dir_q;
        valid_q   <= 1'b0;
      end else if (!bus.stall) begin
        dir_q     <= seq_pc;
        inst_pc_q <= dir_q;
        // Leaving FILL, memory has only just started reading: still a bubble.
        valid_q   <= (state != FILL);
      end
    end
  end

  assign bus.Dir         = dir_q;
  assign bus.pc_plus4    = seq_pc;
  assign bus.inst_pc     = inst_pc_q;
  assign bus.inst_valid  = valid_q;
  assign bus.addr_err    = err_q;
  assign bus.fetch_count = count_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: abstract fetch model checked every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_fetch_pc;
  localparam int unsigned MEM = 80;

  logic clk;
  logic rst;
  fetch_pc_if bus ();

  fetch_pc #(.MEM_BYTES(MEM), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: "primed" = the word being read now is on the correct path
  logic [31:0] m_dir, m_ipc;
  logic        m_valid, m_err, m_primed, m_live;
  logic [15:0] m_cnt;
  initial m_live = 1'b0;

  function automatic logic [31:0] succ(input logic [31:0] a);
    logic [31:0] s;
    s = a + 32'd4;
    return (s > MEM - 4) ? 32'd0 : s;
  endfunction

  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_dir = 0; m_ipc = 0; m_valid = 0; m_err = 0; m_cnt = 0;
      m_primed = 0; m_live = 1;
    end else if (m_live) begin
      if (!bus.stall && m_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (bus.br_taken) begin
        m_ipc   = m_dir;
        m_valid = 0;
        t = {bus.br_target[31:2], 2'b00};
        if (t > MEM - 4) begin
          m_dir = 0;
          m_err = 1;
        end else m_dir = t;
        m_primed = 1;
      end else if (!bus.stall) begin
        m_ipc    = m_dir;
        m_valid  = m_primed;
        m_dir    = succ(m_dir);
        m_primed = 1;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_live) begin
      chk("dir", bus.Dir, m_dir);
      chk("pc_plus4", bus.pc_plus4, succ(m_dir));
      chk("inst_pc", bus.inst_pc, m_ipc);
      chk("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
      chk("addr_err", 32'(bus.addr_err), 32'(m_err));
      chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
    end
  end

  // driver tasks: inputs change at negedge, DUT samples at next posedge
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r;
    bus.stall = s;
    bus.br_taken = b;
    bus.br_target = t;
    @(negedge clk);
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0);
  endtask

  typedef struct packed {
    logic        s;
    logic        b;
    logic [31:0] t;
  } vec_t;

  vec_t mix [10];

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 32'd0;
    @(negedge clk);
    cyc(1, 0, 0, 0);
    chk("rst_dir", bus.Dir, 0);
    chk("rst_ipc", bus.inst_pc, 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_cnt", 32'(bus.fetch_count), 0);
    chk("rst_err", 32'(bus.addr_err), 0);
    chk("rst_state", 32'(bus.fsm_state), 0);

    // sequential run
    free(1);
    chk("seq1_dir", bus.Dir, 4);
    chk("seq1_valid", 32'(bus.inst_valid), 0);
    free(1);
    chk("seq2_dir", bus.Dir, 8);
    chk("seq2_ipc", bus.inst_pc, 4);
    chk("seq2_valid", 32'(bus.inst_valid), 1);
    free(4);
    chk("seq6_dir", bus.Dir, 24);
    chk("seq6_cnt", 32'(bus.fetch_count), 4);

    // wrap at the top of memory
    free(13);
    chk("wrap_dir", bus.Dir, 76);
    chk("wrap_p4", bus.pc_plus4, 0);
    free(1);
    chk("wrap_dir0", bus.Dir, 0);
    chk("wrap_ipc76", bus.inst_pc, 76);
    chk("wrap_valid", 32'(bus.inst_valid), 1);
    free(1);
    chk("wrap_ipc0", bus.inst_pc, 0);
    chk("wrap_valid2", 32'(bus.inst_valid), 1);

    // branch with unaligned target
    free(2);
    chk("br_pre_dir", bus.Dir, 12);
    cyc(0, 0, 1, 32'h22);
    chk("br_dir", bus.Dir, 32);
    chk("br_ipc", bus.inst_pc, 12);
    chk("br_valid", 32'(bus.inst_valid), 0);
    chk("br_state", 32'(bus.fsm_state), 2);
    free(1);
    chk("br_after_ipc", bus.inst_pc, 32);
    chk("br_after_valid", 32'(bus.inst_valid), 1);
    chk("br_after_state", 32'(bus.fsm_state), 1);

    // stall then branch during stall
    cyc(1, 0, 0, 0);
    free(5);
    chk("st_pre_dir", bus.Dir, 20);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("st_dir", bus.Dir, 20);
      chk("st_ipc", bus.inst_pc, 16);
      chk("st_cnt", 32'(bus.fetch_count), 3);
    end
    cyc(0, 1, 1, 32'd40);
    chk("stbr_dir", bus.Dir, 40);
    chk("stbr_ipc", bus.inst_pc, 20);
    chk("stbr_cnt", 32'(bus.fetch_count), 3);

    // back-to-back redirects, one out of range
    cyc(0, 0, 1, 32'h100);
    chk("oor_dir", bus.Dir, 0);
    chk("oor_err", 32'(bus.addr_err), 1);
    chk("oor_valid", 32'(bus.inst_valid), 0);
    cyc(0, 0, 1, 32'd8);
    chk("rr_dir", bus.Dir, 8);
    chk("rr_valid", 32'(bus.inst_valid), 0);
    chk("rr_err", 32'(bus.addr_err), 1);
    free(1);
    chk("rr_after_ipc", bus.inst_pc, 8);
    chk("rr_after_err", 32'(bus.addr_err), 1);

    // reset during REDIRECT
    cyc(0, 0, 1, 32'h30);
    chk("mr_state_pre", 32'(bus.fsm_state), 2);
    cyc(1, 0, 1, 32'h30);
    chk("mr_dir", bus.Dir, 0);
    chk("mr_valid", 32'(bus.inst_valid), 0);
    chk("mr_cnt", 32'(bus.fetch_count), 0);
    chk("mr_err", 32'(bus.addr_err), 0);
    chk("mr_state", 32'(bus.fsm_state), 0);
    cyc(0, 1, 0, 0);
    chk("fill_stall_state", 32'(bus.fsm_state), 0);
    chk("fill_stall_dir", bus.Dir, 0);

    // mixed vectors, checked by the model
    mix[0] = '{1'b0, 1'b0, 32'd0};
    mix[1] = '{1'b0, 1'b0, 32'd0};
    mix[2] = '{1'b0, 1'b1, 32'd76};
    mix[3] = '{1'b0, 1'b0, 32'd0};
    mix[4] = '{1'b1, 1'b0, 32'd0};
    mix[5] = '{1'b0, 1'b1, 32'd79};
    mix[6] = '{1'b1, 1'b1, 32'd80};
    mix[7] = '{1'b0, 1'b0, 32'd0};
    mix[8] = '{1'b0, 1'b0, 32'd0};
    mix[9] = '{1'b1, 1'b0, 32'd0};
    for (int i = 0; i < 10; i++) cyc(0, mix[i].s, mix[i].b, mix[i].t);

    // saturation of the delivered-word counter
    free(65545);
    chk("sat_cnt", 32'(bus.fetch_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
